serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtractor computing a - b - bin, one bit per clock, LSB first. It is the inverse-direction companion to the combinational ripple-carry adder in the arithmetic library. Results are checked against `a + (~b) + ~bin` from the adder. A start/busy/done handshake lets generator/driver benches feed operands back to back.

Parameters:
WIDTH, 4, operand and difference width in bits (legal range WIDTH >= 2).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; latched when start is accepted.
b  input  WIDTH  subtrahend; latched when start is accepted.
bin  input  1  borrow-in; latched when start is accepted.
diff  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
busy  output  1  high in SHIFT state.
done  output  1  one-cycle pulse when diff/bout become valid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; diff=0, bout=0, busy=0, done=0.
  - bit counter=0; internal operand and borrow registers=0.
- States: IDLE, SHIFT, DONE. Encoded as a package enum.
- IDLE:
  - If start=1 at an edge: latch a, b, bin into shift registers, clear counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each edge processes bit[cnt] through the 1-bit full subtractor.
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the result register MSB; operands shift right; cnt increments.
  - On the edge where cnt == WIDTH-1, go to DONE.
  - On that same edge, diff and bout load the final result.
  - busy=1 for exactly WIDTH cycles.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Unconditionally returns to IDLE.
  - start asserted during DONE is ignored.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- Output hold: diff and bout hold their last result until the next completion. They do not change at start acceptance or mid-shift.
- start while busy or in DONE: ignored. Operands are not re-latched; the in-flight operation is unaffected.
- Input changes on a/b/bin after acceptance: no effect.
- Reset mid-operation: immediate abort to IDLE. All outputs return to 0 and no done pulse is produced.
- Width rules:
  - Counter width is $clog2(WIDTH).
  - Wrap-around is modulo 2^WIDTH; the borrow appears only on bout.
- No X propagation from an unused start: all registers have reset values.

Decomposition:
- Package serial_sub_pkg contains:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
  - a localparam for the default WIDTH.
- Sub-module full_subtractor: purely combinational.
  - Inputs x, y, bi; outputs d, bo.
  - One instance in the datapath, mirroring the full-adder cell of the ripple-carry adder.

Test Plan:
1. Reset: rst high with start/a/b toggling. Required: diff=0, bout=0, busy=0, done=0 throughout; after release the FSM stays in IDLE with start=0.
2. Basic subtract, WIDTH=4: a=9, b=3, bin=0, start one cycle. Required: busy high for 4 cycles, then done pulses for 1 cycle with diff=4'h6, bout=0.
3. Underflow cases:
   - a=3, b=9, bin=0: required diff=4'hA, bout=1.
   - a=0, b=0, bin=1: required diff=4'hF, bout=1.
   - a=F, b=F, bin=0: required diff=0, bout=0.
4. Start while busy: start a=8, b=1; two cycles later assert start with a=2, b=5. Required: single done with diff=4'h7, bout=0; the second request is dropped and the FSM returns to IDLE.
5. Reset mid-operation: start a=C, b=4, then assert rst after 2 SHIFT cycles. Required: immediate zero outputs, no done pulse. A subsequent a=C, b=4 gives diff=8, bout=0.
6. Random regression: 500 back-to-back transactions at WIDTH+2 spacing. Required: scoreboard matches {bout, diff} against the reference model a - b - bin computed in WIDTH+1 bits; zero mismatches.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and defaults for the bit-serial subtractor.
//   sub_state_t : control FSM state encoding (IDLE, SHIFT, DONE)
//   DEF_WIDTH   : default operand / difference width in bits
// -----------------------------------------------------------------------------
package serial_sub_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational full subtractor: computes x - y - bi.
// This is the subtract-direction counterpart of the ripple-carry full-adder cell.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   // Borrow when x=0 and y=1, or when x==y and a borrow is already pending.
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing (a - b - bin) mod 2^WIDTH, one bit per clock,
// LSB first, with a start/busy/done handshake.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, sampled only while idle
//   a     : minuend, latched on start acceptance
//   b     : subtrahend, latched on start acceptance
//   bin   : borrow in, latched on start acceptance
//   diff  : difference, updated only on completion
//   bout  : borrow out (a < b + bin, unsigned), updated only on completion
//   busy  : high while bits are being processed (WIDTH cycles)
//   done  : one-cycle pulse when diff/bout hold a new result
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   sub_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             br_q,    br_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic [WIDTH-1:0] diff_q,  diff_d;
   logic             bout_q,  bout_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic             fs_d;
   logic             fs_bo;
   logic [WIDTH-1:0] res_shift;

   // Single bit cell; always looks at the current LSB of the operand shifters.
   full_subtractor u_fs (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .bi (br_q),
      .d  (fs_d),
      .bo (fs_bo)
   );

   // New difference bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
   assign res_shift = {fs_d, res_q[WIDTH-1:1]};

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            br_d  = fs_bo;
            res_d = res_shift;
            cnt_d = cnt_q + CNT_W'(1);
            // Last bit: publish the result on the same edge that enters DONE.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d  = res_shift;
               bout_d  = fs_bo;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the upcoming state.
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus a
// randomized back-to-back regression against an integer-arithmetic model.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;
   logic         done;

   int           n_checks;
   int           n_fail;

   // Last completed result; outputs must hold this between completions.
   logic [W-1:0] hold_diff;
   logic         hold_bout;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: plain signed integer subtraction, wrapped to W bits.
   task automatic model(input int av, input int bv, input int binv,
                        output logic [W-1:0] d, output logic bo);
      int r;
      r  = av - bv - binv;
      bo = (r < 0);
      d  = W'(r + (1 << W));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_diff"}, 32'(diff), 32'd0);
      check({tag, "_bout"}, 32'(bout), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // One transaction at minimum spacing. mode 0: quiet start during op,
   // mode 1: one stray request (a=2,b=5) two cycles after start,
   // mode 2: random start pulses while busy and in DONE.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic binv, input int mode);
      logic [W-1:0] exp_d;
      logic         exp_b;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      start = 1'b1;
      a     = av;
      b     = bv;
      bin   = binv;
      model(int'(av), int'(bv), int'(binv), exp_d, exp_b);
      for (int i = 0; i < int'(W); i++) begin
         @(negedge clk);
         check("shift_busy", 32'(busy), 32'd1);
         check("shift_done", 32'(done), 32'd0);
         check("hold_diff",  32'(diff), 32'(hold_diff));
         check("hold_bout",  32'(bout), 32'(hold_bout));
         start = 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
         bin   = 1'($urandom);
         if (mode == 1 && i == 1) begin
            start = 1'b1;
            a     = W'(2);
            b     = W'(5);
            bin   = 1'b0;
         end
         if (mode == 2) start = 1'($urandom);
      end
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy",  32'(busy), 32'd0);
      check("res_diff",   32'(diff), 32'(exp_d));
      check("res_bout",   32'(bout), 32'(exp_b));
      hold_diff = exp_d;
      hold_bout = exp_b;
      start = (mode == 2) ? 1'($urandom) : 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      hold_diff = '0;
      hold_bout = 1'b0;
      rst   = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;

      // Reset held with inputs toggling: everything stays zero.
      #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_all_zero("rst");
         start = 1'($urandom);
         a     = W'($urandom);
         b     = W'($urandom);
         bin   = 1'($urandom);
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_all_zero("post_rst");
      end

      // Basic and underflow cases.
      run_op(W'(9),  W'(3),  1'b0, 0);
      run_op(W'(3),  W'(9),  1'b0, 0);
      run_op(W'(0),  W'(0),  1'b1, 0);
      run_op(W'(15), W'(15), 1'b0, 0);

      // Request while busy is dropped; FSM settles in IDLE.
      run_op(W'(8), W'(1), 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("drop_busy", 32'(busy), 32'd0);
         check("drop_done", 32'(done), 32'd0);
         check("drop_diff", 32'(diff), 32'h7);
      end

      // Reset mid-operation: immediate zeros, no done.
      @(negedge clk);
      start = 1'b1;
      a     = W'(12);
      b     = W'(4);
      bin   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("abort");
      hold_diff = '0;
      hold_bout = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_all_zero("abort_hold");
      end
      rst = 1'b0;
      run_op(W'(12), W'(4), 1'b0, 0);

      // Random back-to-back regression.
      for (int n = 0; n < 500; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 1)) * 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_subtractor
